// File: rtl/seven_display.sv
// seven_display: four-digit multiplexed hex display driver around a 16-bit
// up/down counter stepped by a debounced push-button.
//   MHzclk          system clock, rising edge
//   reset           async active-low reset
//   button          raw bouncy push-button, high = pressed
//   switch_control  direction: 0 = count up, 1 = count down
//   AN[3:0]         digit anodes, active-low, AN[0] = rightmost digit
//   seven[6:0]      segments {a,b,c,d,e,f,g}, active-low
module seven_display #(
  parameter int REFRESH_DIV     = 1000,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       MHzclk,
  input  logic       reset,
  input  logic       button,
  input  logic       switch_control,
  output logic [3:0] AN,
  output logic [6:0] seven
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1_q, btn_s2_q, sw_s1_q, sw_s2_q;
  logic          acc_q, acc_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [15:0]   value_q, value_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic          flip, step;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Flip the accepted level on the DEBOUNCE_CYCLES-th consecutive differing
  // cycle; a step is the rising flip, taken in the same cycle it is accepted.
  assign flip = (btn_s2_q != acc_q) && (db_cnt_q == DB_LAST);
  assign step = flip && !acc_q;

  always_comb begin
    acc_d    = acc_q;
    db_cnt_d = '0;
    if (btn_s2_q != acc_q) begin
      if (flip) acc_d = ~acc_q;
      else      db_cnt_d = db_cnt_q + 1'b1;
    end

    value_d = value_q;
    if (step) value_d = sw_s2_q ? value_q - 16'd1 : value_q + 16'd1;

    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end

    case (idx_q)
      2'd0:    nib = value_q[3:0];
      2'd1:    nib = value_q[7:4];
      2'd2:    nib = value_q[11:8];
      default: nib = value_q[15:12];
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = hex7(nib);
  end

  always_ff @(posedge MHzclk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= 1'b0;
      sw_s2_q  <= 1'b0;
      acc_q    <= 1'b0;
      db_cnt_q <= '0;
      value_q  <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b0000001;
    end else begin
      btn_s1_q <= button;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switch_control;
      sw_s2_q  <= sw_s1_q;
      acc_q    <= acc_d;
      db_cnt_q <= db_cnt_d;
      value_q  <= value_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign AN    = an_q;
  assign seven = seg_q;

endmodule

// File: tb/tb_seven_display.sv
module tb_seven_display;

  logic       MHzclk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       switch_control = 1'b0;
  logic [3:0] AN;
  logic [6:0] seven;

  int errs = 0;
  int checks = 0;

  seven_display #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .MHzclk(MHzclk), .reset(reset), .button(button),
    .switch_control(switch_control), .AN(AN), .seven(seven)
  );

  always begin
    #5;
    if (clk_en) MHzclk = ~MHzclk;
  end

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;  4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;  4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;  4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;  4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;  4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;  default: seg = 7'b0111000;
    endcase
  endfunction

  task automatic press();
    button = 1'b1;
    repeat (20) @(negedge MHzclk);
    button = 1'b0;
    repeat (20) @(negedge MHzclk);
  endtask

  task automatic do_reset();
    @(negedge MHzclk);
    reset = 1'b0;
    @(negedge MHzclk);
    reset = 1'b1;
  endtask

  // Watch 16 cycles (every digit at least once) and check each lit digit.
  task automatic check_display(input string name, input logic [15:0] v);
    logic [3:0] nib;
    logic [6:0] exp;
    for (int k = 0; k < 16; k++) begin
      @(negedge MHzclk);
      checks++;
      case (AN)
        4'b1110: nib = v[3:0];
        4'b1101: nib = v[7:4];
        4'b1011: nib = v[11:8];
        4'b0111: nib = v[15:12];
        default: nib = 4'hx;
      endcase
      exp = seg(nib);
      if ($isunknown(nib) || seven !== exp) begin
        errs++;
        $display("FAIL %s: AN=%b seven=%b, required one-hot-low AN and seven=%b for value %h",
                 name, AN, seven, exp, v);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_an;
    one = 4'b0001;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (AN !== 4'b1110) begin errs++; $display("FAIL reset_an: got %b want 1110", AN); end
    checks++;
    if (seven !== 7'b0000001) begin errs++; $display("FAIL reset_seg: got %b want 0000001", seven); end
    clk_en = 1'b1;
    repeat (3) @(negedge MHzclk);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge MHzclk);
      exp_an = ~(one << (((k - 1) / 4) % 4));
      checks++;
      if (AN !== exp_an || seven !== 7'b0000001) begin
        errs++;
        $display("FAIL scan_k%0d: AN=%b seven=%b want AN=%b seven=0000001", k, AN, seven, exp_an);
      end
    end
  endtask

  task automatic test_up_count();
    switch_control = 1'b0;
    repeat (3) press();
    check_display("up_count", 16'h0003);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 10; k++) begin
      button = ~button;
      repeat (2) @(negedge MHzclk);
    end
    button = 1'b1;
    repeat (10) @(negedge MHzclk);
    button = 1'b0;
    repeat (20) @(negedge MHzclk);
    check_display("bounce", 16'h0004);
  endtask

  task automatic test_down_wrap();
    do_reset();
    switch_control = 1'b1;
    repeat (5) @(negedge MHzclk);
    press();
    check_display("down_wrap", 16'hFFFF);
  endtask

  task automatic test_up_wrap();
    switch_control = 1'b0;
    repeat (5) @(negedge MHzclk);
    press();
    check_display("up_wrap", 16'h0000);
    repeat (26) press();
    check_display("up_1a", 16'h001A);
  endtask

  task automatic test_reset_mid();
    do_reset();
    switch_control = 1'b0;
    repeat (5) press();
    check_display("pre_mid", 16'h0005);
    button = 1'b1;
    repeat (3) @(negedge MHzclk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (AN !== 4'b1110 || seven !== 7'b0000001) begin
      errs++;
      $display("FAIL mid_reset: AN=%b seven=%b want 1110/0000001", AN, seven);
    end
    @(negedge MHzclk);
    reset = 1'b1;
    repeat (20) @(negedge MHzclk);
    check_display("held_after_reset", 16'h0001);
    button = 1'b0;
    repeat (20) @(negedge MHzclk);
    check_display("released_after_reset", 16'h0001);
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_bounce();
    test_down_wrap();
    test_up_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
